// File: rtl/data_island_packet_serializer.sv
// Data island packet serializer.
// Captures one HDMI data island packet (24-bit header plus four 56-bit
// subpackets) and emits it over 32 pixel clocks as 9-bit TERC4 payload
// slices. BCH parity bytes are generated on the fly and appended to the
// header lane (last 8 slices) and to each subpacket lane (last 4 slices).
module data_island_packet_serializer #(
    parameter logic [7:0] ECC_POLY = 8'h83
) (
    input  logic         clk_pixel,
    input  logic         reset,
    input  logic         data_island_period,
    input  logic [23:0]  header,
    input  logic [223:0] sub,
    output logic [8:0]   packet_data,
    output logic         packet_load,
    output logic         packet_done
);

    // One serial step of the reflected BCH generator.
    function automatic logic [7:0] ecc_step(input logic [7:0] ecc, input logic din);
        logic fb;
        fb = ecc[0] ^ din;
        return {1'b0, ecc[7:1]} ^ (fb ? ECC_POLY : 8'h00);
    endfunction

    logic [4:0]   index_r;
    logic [23:0]  hdr_r;
    logic [223:0] sub_r;
    logic [7:0]   ecc_h_r;
    logic [31:0]  ecc_sub_r;
    logic [8:0]   packet_data_r;
    logic         packet_done_r;

    logic         start_s;
    logic [23:0]  hdr_s;
    logic [223:0] sub_s;
    logic [7:0]   ecc_h_base_s;
    logic         hdr_bit_s;
    logic [7:0]   ecc_h_next_s;
    logic [55:0]  lane_s [4];
    logic [7:0]   ecc_base_s [4];
    logic [7:0]   ecc_cur_s [4];
    logic [3:0]   even_s;
    logic [3:0]   odd_s;
    logic [31:0]  ecc_sub_next_s;
    logic [8:0]   slice_s;

    // Index 0 works from the raw inputs with freshly cleared parity;
    // every later index works from the shadow copies.
    always_comb begin
        start_s      = (index_r == 5'd0);
        hdr_s        = start_s ? header : hdr_r;
        sub_s        = start_s ? sub : sub_r;
        ecc_h_base_s = start_s ? 8'h00 : ecc_h_r;
        hdr_bit_s    = 1'b0;
        ecc_h_next_s = ecc_h_r;
        even_s       = 4'h0;
        odd_s        = 4'h0;
        ecc_sub_next_s = ecc_sub_r;
        for (int k = 0; k < 4; k++) begin
            lane_s[k]     = sub_s[56*k +: 56];
            ecc_cur_s[k]  = ecc_sub_r[8*k +: 8];
            ecc_base_s[k] = start_s ? 8'h00 : ecc_cur_s[k];
        end

        if (index_r[4:3] != 2'b11) begin
            hdr_bit_s    = hdr_s[index_r];
            ecc_h_next_s = ecc_step(ecc_h_base_s, hdr_bit_s);
        end else begin
            hdr_bit_s    = ecc_h_r[index_r[2:0]];
            ecc_h_next_s = ecc_h_r;
        end

        for (int k = 0; k < 4; k++) begin
            if (index_r[4:2] != 3'b111) begin
                even_s[k] = lane_s[k][{index_r, 1'b0}];
                odd_s[k]  = lane_s[k][{index_r, 1'b1}];
                ecc_sub_next_s[8*k +: 8] =
                    ecc_step(ecc_step(ecc_base_s[k], even_s[k]), odd_s[k]);
            end else begin
                even_s[k] = ecc_cur_s[k][{index_r[1:0], 1'b0}];
                odd_s[k]  = ecc_cur_s[k][{index_r[1:0], 1'b1}];
                ecc_sub_next_s[8*k +: 8] = ecc_cur_s[k];
            end
        end

        slice_s = {odd_s, even_s, hdr_bit_s};
    end

    // Load strobe coincides with the capture cycle so upstream can advance.
    assign packet_load = data_island_period & start_s & ~reset;
    assign packet_data = packet_data_r;
    assign packet_done = packet_done_r;

    // Packet sequencing, shadow capture, parity accumulation and output slice.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            index_r       <= 5'd0;
            hdr_r         <= 24'h000000;
            sub_r         <= 224'd0;
            ecc_h_r       <= 8'h00;
            ecc_sub_r     <= 32'h0000_0000;
            packet_data_r <= 9'h000;
            packet_done_r <= 1'b0;
        end else if (data_island_period) begin
            index_r       <= index_r + 5'd1;
            ecc_h_r       <= ecc_h_next_s;
            ecc_sub_r     <= ecc_sub_next_s;
            packet_data_r <= slice_s;
            packet_done_r <= (index_r == 5'd31);
            if (start_s) begin
                hdr_r <= header;
                sub_r <= sub;
            end else begin
                hdr_r <= hdr_r;
                sub_r <= sub_r;
            end
        end else begin
            // Idle or aborted packet: restart cleanly at the next period.
            index_r       <= 5'd0;
            hdr_r         <= hdr_r;
            sub_r         <= sub_r;
            ecc_h_r       <= 8'h00;
            ecc_sub_r     <= 32'h0000_0000;
            packet_data_r <= 9'h000;
            packet_done_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_island_packet_serializer.sv
// Scoreboard bench for data_island_packet_serializer: stimulus pushes the
// expected slice for every driven cycle, a monitor pops and compares.
module tb_data_island_packet_serializer;

    logic         clk_pixel = 1'b0;
    logic         reset;
    logic         data_island_period;
    logic [23:0]  header;
    logic [223:0] sub;
    logic [8:0]   packet_data;
    logic         packet_load;
    logic         packet_done;

    always #5 clk_pixel = ~clk_pixel;

    data_island_packet_serializer dut (
        .clk_pixel          (clk_pixel),
        .reset              (reset),
        .data_island_period (data_island_period),
        .header             (header),
        .sub                (sub),
        .packet_data        (packet_data),
        .packet_load        (packet_load),
        .packet_done        (packet_done)
    );

    typedef struct {
        logic [8:0] data;
        logic       done;
        string      tag;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         tests = 0;
    int         fails = 0;
    logic [8:0] gold [32];

    function automatic logic [7:0] bch(input logic [7:0] e, input logic b);
        logic fb;
        fb = e[0] ^ b;
        return (e >> 1) ^ (fb ? 8'h83 : 8'h00);
    endfunction

    function automatic logic [223:0] rand_sub();
        logic [223:0] r;
        for (int i = 0; i < 7; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Bit-serial golden model: whole header / whole subpacket through BCH.
    task automatic build_gold(input logic [23:0] h, input logic [223:0] s);
        logic [7:0] he;
        logic [7:0] se [4];
        he = 8'h00;
        for (int i = 0; i < 24; i++) he = bch(he, h[i]);
        for (int k = 0; k < 4; k++) begin
            se[k] = 8'h00;
            for (int i = 0; i < 56; i++) se[k] = bch(se[k], s[56*k + i]);
        end
        for (int n = 0; n < 32; n++) begin
            gold[n] = 9'h000;
            gold[n][0] = (n < 24) ? h[n] : he[n-24];
            for (int k = 0; k < 4; k++) begin
                if (n < 28) begin
                    gold[n][1+k] = s[56*k + 2*n];
                    gold[n][5+k] = s[56*k + 2*n + 1];
                end else begin
                    gold[n][1+k] = se[k][2*(n-28)];
                    gold[n][5+k] = se[k][2*(n-28)+1];
                end
            end
        end
    endtask

    task automatic drive(input logic rst, input logic per, input logic [23:0] h,
                         input logic [223:0] s, input logic [8:0] ed,
                         input logic edone, input logic eload, input string tag);
        exp_t e;
        @(negedge clk_pixel);
        reset = rst;
        data_island_period = per;
        header = h;
        sub = s;
        e.data = ed;
        e.done = edone;
        e.tag = tag;
        exp_q.push_back(e);
        #1;
        tests++;
        if (packet_load !== eload) begin
            fails++;
            $display("FAIL %s packet_load: got %b expected %b", tag, packet_load, eload);
        end
    endtask

    task automatic send_packet(input logic [23:0] h, input logic [223:0] s,
                               input logic scramble, input string tag);
        build_gold(h, s);
        for (int n = 0; n < 32; n++) begin
            if (n == 0 || !scramble)
                drive(1'b0, 1'b1, h, s, gold[n], n == 31, n == 0, tag);
            else
                drive(1'b0, 1'b1, 24'($urandom), rand_sub(), gold[n], n == 31, 1'b0, tag);
        end
    endtask

    task automatic send_partial(input logic [23:0] h, input logic [223:0] s,
                                input int ncyc, input string tag);
        build_gold(h, s);
        for (int n = 0; n < ncyc; n++)
            drive(1'b0, 1'b1, (n == 0) ? h : 24'($urandom), (n == 0) ? s : rand_sub(),
                  gold[n], 1'b0, n == 0, tag);
    endtask

    task automatic idle(input int ncyc, input string tag);
        for (int n = 0; n < ncyc; n++)
            drive(1'b0, 1'b0, 24'($urandom), rand_sub(), 9'h000, 1'b0, 1'b0, tag);
    endtask

    // Monitor: compare each registered slice against the queued expectation.
    initial begin
        forever begin
            @(posedge clk_pixel);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                tests++;
                if (packet_data !== mon_e.data || packet_done !== mon_e.done) begin
                    fails++;
                    $display("FAIL %s: packet_data=%h packet_done=%b expected %h %b",
                             mon_e.tag, packet_data, packet_done, mon_e.data, mon_e.done);
                end
            end
        end
    end

    // Directed stimulus sequence.
    initial begin
        logic [7:0]   acr_ecc;
        logic [8:0]   ed;
        logic [223:0] s_ones;
        reset = 1'b1;
        data_island_period = 1'b0;
        header = 24'h000000;
        sub = 224'd0;

        // Reset state
        drive(1'b1, 1'b0, 24'h000000, 224'd0, 9'h000, 1'b0, 1'b0, "reset_state");
        drive(1'b1, 1'b1, 24'hABCDEF, 224'd5, 9'h000, 1'b0, 1'b0, "reset_state");
        idle(2, "idle");

        // ACR header, hand-computed slices: 1, 23 zeros, ECC 0x4A LSB-first
        acr_ecc = 8'h4A;
        for (int n = 0; n < 32; n++) begin
            ed = 9'h000;
            if (n == 0) ed[0] = 1'b1;
            else if (n >= 24) ed[0] = acr_ecc[n-24];
            drive(1'b0, 1'b1, 24'h000001, 224'd0, ed, n == 31, n == 0, "acr");
        end
        idle(1, "idle");

        // All-zero packet
        for (int n = 0; n < 32; n++)
            drive(1'b0, 1'b1, 24'h000000, 224'd0, 9'h000, n == 31, n == 0, "zero_pkt");
        idle(2, "idle");

        // sub0 all ones, others zero
        s_ones = 224'd0;
        s_ones[55:0] = 56'hFF_FFFF_FFFF_FFFF;
        send_packet(24'h000000, s_ones, 1'b0, "sub0_ones");

        // Abort at index 12, period back 3 cycles later
        send_partial(24'($urandom), rand_sub(), 12, "abort_head");
        idle(3, "abort_gap");
        send_packet(24'($urandom), rand_sub(), 1'b0, "after_abort");

        // Reset pulsed at index 20
        send_partial(24'($urandom), rand_sub(), 20, "rst_head");
        drive(1'b1, 1'b1, 24'($urandom), rand_sub(), 9'h000, 1'b0, 1'b0, "rst_pulse");
        send_packet(24'($urandom), rand_sub(), 1'b0, "after_reset");

        // 1000 random packets back-to-back, inputs scrambled after index 0
        for (int p = 0; p < 1000; p++)
            send_packet(24'($urandom), rand_sub(), 1'b1, "random_b2b");
        idle(2, "tail");

        @(posedge clk_pixel);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
